gate_sweep_ctrl: RTL and testbench

Self-test sequencer for one shared combinational basic-gate instance (NOT, AND, OR, NAND, NOR, XOR, XNOR).
- On a start request it drives every input combination into the gate, in ascending binary order.
- It waits a programmable settle time, samples the gate output and compares it against the expected truth-table value.
- It reports pass/fail, error count and the first failing vector.
- It sits beside the basic-gate library as the on-chip replacement for manual truth-table benches.

---
 rtl/gate_sweep_ctrl.sv | 166 ++++++++++++++++
 tb/tb_gate_sweep_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// gate_sweep_ctrl
// Self-test sequencer for one shared combinational basic gate. On an accepted
// start it drives every input combination into the gate in ascending binary
// order. Each vector is held for a settle time, then the gate output is
// compared against the expected truth-table value. The block reports pass,
// the error count and the first failing vector.
//
// Parameters
//   N_IN    : number of gate inputs (1..8); NOT uses bit 0 only
//   SETTLE  : cycles gate_a is held before gate_y is sampled (0 acts as 1)
//   GATE_OP : 0=NOT 1=AND 2=OR 3=NAND 4=NOR 5=XOR 6=XNOR (7 checked as NOT)
//
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   start     : single-cycle sweep request, honoured only in IDLE
//   gate_a    : registered input vector to the gate under test
//   gate_y    : gate-under-test output, sampled only in CHECK
//   busy      : high while a sweep is running (not in the DONE cycle)
//   done      : one-cycle pulse when the sweep completes
//   pass      : last sweep had no mismatches; cleared on an accepted start
//   err_count : mismatching vectors in the current or last sweep
//   fail_vec  : first mismatching vector, valid when err_count != 0
// ---------------------------------------------------------------------------
module gate_sweep_ctrl #(
  parameter int N_IN    = 2,
  parameter int SETTLE  = 1,
  parameter int GATE_OP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] gate_a,
  input  logic            gate_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] fail_vec
);

  // A zero settle time still needs one WAIT cycle so gate_a is registered
  // and stable before the comparison.
  localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam int CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_EFF - 1);
  localparam logic [N_IN-1:0]  ALL_ONES = {N_IN{1'b1}};
  localparam logic [2:0]       OP       = 3'(GATE_OP);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] settle_cnt_r;

  logic             mismatch_s;
  logic [N_IN:0]    err_inc_s;

  // Truth-table value the gate must produce for input vector a.
  function automatic logic expected_y(input logic [N_IN-1:0] a);
    logic y;
    case (OP)
      3'd1:    y = &a;
      3'd2:    y = |a;
      3'd3:    y = ~(&a);
      3'd4:    y = ~(|a);
      3'd5:    y = ^a;
      3'd6:    y = ~(^a);
      default: y = ~a[0];  // NOT, and the reserved code 7
    endcase
    return y;
  endfunction

  // Compare the gate output with the truth table and form the error count
  // that includes the vector currently being checked.
  always_comb begin
    mismatch_s = 1'b0;
    err_inc_s  = err_count;
    if (gate_y != expected_y(gate_a)) begin
      mismatch_s = 1'b1;
      err_inc_s  = err_count + (N_IN+1)'(1'b1);
    end else begin
      mismatch_s = 1'b0;
      err_inc_s  = err_count;
    end
  end

  // Sweep FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      settle_cnt_r <= {CNT_W{1'b0}};
      gate_a       <= {N_IN{1'b0}};
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_count    <= {(N_IN+1){1'b0}};
      fail_vec     <= {N_IN{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state_r      <= ST_WAIT;
            settle_cnt_r <= {CNT_W{1'b0}};
            gate_a       <= {N_IN{1'b0}};
            err_count    <= {(N_IN+1){1'b0}};
            fail_vec     <= {N_IN{1'b0}};
            pass         <= 1'b0;
            busy         <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_WAIT: begin
          if (settle_cnt_r == CNT_LAST) begin
            state_r <= ST_CHECK;
          end else begin
            settle_cnt_r <= settle_cnt_r + CNT_W'(1'b1);
          end
        end

        ST_CHECK: begin
          err_count <= err_inc_s;
          // Only the first mismatch of a sweep is recorded.
          if (mismatch_s && (err_count == {(N_IN+1){1'b0}})) begin
            fail_vec <= gate_a;
          end else begin
            fail_vec <= fail_vec;
          end
          // The all-ones vector is the last one; no wrap-around.
          if (gate_a == ALL_ONES) begin
            state_r <= ST_DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
            pass    <= (err_inc_s == {(N_IN+1){1'b0}});
          end else begin
            gate_a       <= gate_a + N_IN'(1'b1);
            settle_cnt_r <= {CNT_W{1'b0}};
            state_r      <= ST_WAIT;
          end
        end

        ST_DONE: begin
          // start is ignored here; it is first honoured in the next IDLE cycle.
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gate_sweep_ctrl
// Five differently configured sequencers, each driving its own modelled gate.
// The gate model can be correct, flip chosen vectors, stick at 0/1 or behave
// as OR. A reference model derives the expected vector timeline, error list
// and final status from the truth-table rules using plain arithmetic.
// ---------------------------------------------------------------------------
module tb_gate_sweep_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start_a [5];
  logic gy_a    [5];
  logic busy_a  [5];
  logic done_a  [5];
  logic pass_a  [5];
  int          mode_a [5];
  logic [15:0] flip_a [5];

  logic [0:0] ga0, fv0; logic [1:0] ec0;
  logic [1:0] ga1, fv1; logic [2:0] ec1;
  logic [2:0] ga2, fv2; logic [3:0] ec2;
  logic [1:0] ga3, fv3; logic [2:0] ec3;
  logic [3:0] ga4, fv4; logic [4:0] ec4;

  int n_checks = 0;
  int n_errors = 0;

  // Instance configurations: inputs, effective settle, op
  function automatic int cfg_n(input int k);
    case (k) 0: return 1; 1: return 2; 2: return 3; 3: return 2; default: return 4; endcase
  endfunction
  function automatic int cfg_s(input int k);
    case (k) 0: return 1; 1: return 3; 2: return 1; 3: return 1; default: return 2; endcase
  endfunction
  function automatic int cfg_op(input int k);
    case (k) 0: return 0; 1: return 1; 2: return 4; 3: return 5; default: return 3; endcase
  endfunction

  // Truth table from counting ones in the vector.
  function automatic int truth(input int op, input int n, input int v);
    int ones = 0;
    bit all1, any, odd;
    for (int b = 0; b < n; b++) ones += (v >> b) & 1;
    all1 = (ones == n);
    any  = (ones != 0);
    odd  = (ones % 2) == 1;
    case (op)
      1: return all1 ? 1 : 0;
      2: return any ? 1 : 0;
      3: return all1 ? 0 : 1;
      4: return any ? 0 : 1;
      5: return odd ? 1 : 0;
      6: return odd ? 0 : 1;
      default: return ((v & 1) == 1) ? 0 : 1;
    endcase
  endfunction

  // Gate under test: 0 correct with flips, 1 stuck-0, 2 stuck-1, 3 behaves as OR
  function automatic logic gate_model(input int op, input int n, input int mode,
                                      input logic [15:0] flip, input int v);
    case (mode)
      1: return 1'b0;
      2: return 1'b1;
      3: return (v != 0);
      default: return 1'(truth(op, n, v)) ^ flip[v[3:0]];
    endcase
  endfunction

  assign gy_a[0] = gate_model(cfg_op(0), cfg_n(0), mode_a[0], flip_a[0], int'(ga0));
  assign gy_a[1] = gate_model(cfg_op(1), cfg_n(1), mode_a[1], flip_a[1], int'(ga1));
  assign gy_a[2] = gate_model(cfg_op(2), cfg_n(2), mode_a[2], flip_a[2], int'(ga2));
  assign gy_a[3] = gate_model(cfg_op(3), cfg_n(3), mode_a[3], flip_a[3], int'(ga3));
  assign gy_a[4] = gate_model(cfg_op(4), cfg_n(4), mode_a[4], flip_a[4], int'(ga4));

  gate_sweep_ctrl #(.N_IN(1), .SETTLE(1), .GATE_OP(0)) u0 (
    .clk(clk), .rst(rst), .start(start_a[0]), .gate_a(ga0), .gate_y(gy_a[0]),
    .busy(busy_a[0]), .done(done_a[0]), .pass(pass_a[0]), .err_count(ec0), .fail_vec(fv0));
  gate_sweep_ctrl #(.N_IN(2), .SETTLE(3), .GATE_OP(1)) u1 (
    .clk(clk), .rst(rst), .start(start_a[1]), .gate_a(ga1), .gate_y(gy_a[1]),
    .busy(busy_a[1]), .done(done_a[1]), .pass(pass_a[1]), .err_count(ec1), .fail_vec(fv1));
  gate_sweep_ctrl #(.N_IN(3), .SETTLE(0), .GATE_OP(4)) u2 (
    .clk(clk), .rst(rst), .start(start_a[2]), .gate_a(ga2), .gate_y(gy_a[2]),
    .busy(busy_a[2]), .done(done_a[2]), .pass(pass_a[2]), .err_count(ec2), .fail_vec(fv2));
  gate_sweep_ctrl #(.N_IN(2), .SETTLE(1), .GATE_OP(5)) u3 (
    .clk(clk), .rst(rst), .start(start_a[3]), .gate_a(ga3), .gate_y(gy_a[3]),
    .busy(busy_a[3]), .done(done_a[3]), .pass(pass_a[3]), .err_count(ec3), .fail_vec(fv3));
  gate_sweep_ctrl #(.N_IN(4), .SETTLE(2), .GATE_OP(3)) u4 (
    .clk(clk), .rst(rst), .start(start_a[4]), .gate_a(ga4), .gate_y(gy_a[4]),
    .busy(busy_a[4]), .done(done_a[4]), .pass(pass_a[4]), .err_count(ec4), .fail_vec(fv4));

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic sample(input int k, output int ga, output int bz, output int dn,
                        output int ps, output int ec, output int fv);
    bz = int'(busy_a[k]); dn = int'(done_a[k]); ps = int'(pass_a[k]);
    case (k)
      0: begin ga = int'(ga0); ec = int'(ec0); fv = int'(fv0); end
      1: begin ga = int'(ga1); ec = int'(ec1); fv = int'(fv1); end
      2: begin ga = int'(ga2); ec = int'(ec2); fv = int'(fv2); end
      3: begin ga = int'(ga3); ec = int'(ec3); fv = int'(fv3); end
      default: begin ga = int'(ga4); ec = int'(ec4); fv = int'(fv4); end
    endcase
  endtask

  task automatic check_all(input int k, input string what, input int ga, input int bz,
                           input int dn, input int ps, input int ec, input int fv);
    int g, b, d, p, e, f;
    sample(k, g, b, d, p, e, f);
    check_eq($sformatf("u%0d %s gate_a", k, what), g, ga);
    check_eq($sformatf("u%0d %s busy", k, what), b, bz);
    check_eq($sformatf("u%0d %s done", k, what), d, dn);
    check_eq($sformatf("u%0d %s pass", k, what), p, ps);
    check_eq($sformatf("u%0d %s err_count", k, what), e, ec);
    check_eq($sformatf("u%0d %s fail_vec", k, what), f, fv);
  endtask

  // One sweep on instance k. hold keeps start high throughout; pulse_c > 0
  // pulses start at that edge (counted from the accepting edge); rst_c > 0
  // asserts reset at that edge and abandons the sweep.
  task automatic run_sweep(input int k, input bit hold, input int pulse_c, input int rst_c);
    int n = cfg_n(k);
    int per = cfg_s(k) + 1;
    int nv = 1 << n;
    int len = nv * per;
    int fails[$];
    int e_err, e_fv, e_pass, g, b, d, p, e, f;
    bit seen;
    for (int v = 0; v < nv; v++)
      if (int'(gate_model(cfg_op(k), n, mode_a[k], flip_a[k], v)) != truth(cfg_op(k), n, v))
        fails.push_back(v);
    e_pass = (fails.size() == 0) ? 1 : 0;

    @(negedge clk); start_a[k] = 1'b1;
    @(posedge clk); @(negedge clk);
    if (!hold) start_a[k] = 1'b0;
    for (int c = 0; c <= len + 1; c++) begin
      if (c < len) begin
        e_err = 0; e_fv = 0;
        foreach (fails[i]) if ((fails[i] + 1) * per <= c) e_err++;
        if (e_err != 0) e_fv = fails[0];
        check_all(k, $sformatf("c=%0d", c), c / per, 1, 0, 0, e_err, e_fv);
      end else begin
        check_all(k, $sformatf("c=%0d", c), nv - 1, 0, (c == len) ? 1 : 0, e_pass,
                  fails.size(), (fails.size() != 0) ? fails[0] : 0);
      end
      if (!hold) start_a[k] = (pulse_c > 0 && c == pulse_c - 1) ? 1'b1 : 1'b0;
      if (rst_c > 0 && c == rst_c - 1) begin
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        check_all(k, "after rst", 0, 0, 0, 0, 0, 0);
        for (int j = 0; j < len; j++) begin
          @(posedge clk); @(negedge clk);
          sample(k, g, b, d, p, e, f);
          check_eq($sformatf("u%0d idle after rst busy/done/gate_a", k), b + d + g, 0);
        end
        return;
      end
      @(posedge clk); @(negedge clk);
    end
    if (hold) begin
      // Held start is accepted in the IDLE cycle after DONE.
      check_all(k, "restart", 0, 1, 0, 0, 0, 0);
      start_a[k] = 1'b0;
      seen = 1'b0;
      for (int j = 0; j < len + 4 && !seen; j++) begin
        @(posedge clk); @(negedge clk);
        sample(k, g, b, d, p, e, f);
        if (d == 1) begin
          seen = 1'b1;
          check_eq($sformatf("u%0d second sweep err_count", k), e, fails.size());
          check_eq($sformatf("u%0d second sweep pass", k), p, e_pass);
        end
      end
      check_eq($sformatf("u%0d second sweep done seen", k), int'(seen), 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      start_a[k] = 1'b0; mode_a[k] = 0; flip_a[k] = 16'h0000;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) check_all(k, "reset", 0, 0, 0, 0, 0, 0);

    // NOT, correct gate, then stuck at 0
    mode_a[0] = 0; run_sweep(0, 1'b0, 0, 0);
    mode_a[0] = 1; run_sweep(0, 1'b0, 0, 0);
    // XOR checker with a gate behaving as OR: only vector 3 fails
    mode_a[3] = 3; run_sweep(3, 1'b0, 0, 0);
    // AND, settle 3, stray start at edge 5 ignored
    mode_a[1] = 0; run_sweep(1, 1'b0, 5, 0);
    // Reset at edge 6, then a clean sweep
    run_sweep(1, 1'b0, 0, 6);
    run_sweep(1, 1'b0, 0, 0);
    // NOR stuck at 1 with start held high across DONE
    mode_a[2] = 2; run_sweep(2, 1'b1, 0, 0);
    // Random configurations and fault patterns
    for (int it = 0; it < 12; it++) begin
      int k = $urandom_range(0, 4);
      mode_a[k] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      flip_a[k] = ($urandom_range(0, 2) == 0) ? 16'h0000 : 16'($urandom);
      run_sweep(k, 1'b0, 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
